mem_read_arbiter: RTL and testbench

//   Shares one synchronous-read word memory between two read requesters:

---
 rtl/mem_read_arbiter_if.sv | 43 ++++
 rtl/mem_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter_if
// Brief    : Bundle of the two read-requester ports and the memory-side
//            address/data path of mem_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_read_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32
);
    // Port 0 (instruction fetch)
    logic                  req0;
    logic [ADDRESSLEN-1:0] addr0;
    logic                  gnt0;
    logic                  rvalid0;
    // Port 1 (data load)
    logic                  req1;
    logic [ADDRESSLEN-1:0] addr1;
    logic                  gnt1;
    logic                  rvalid1;
    // Shared response
    logic [XLEN-1:0]       rdata;
    logic                  err;
    logic                  busy;
    // Memory side
    logic [ADDRESSLEN-1:0] mem_addr;
    logic [XLEN-1:0]       mem_rdata;

    // Requesters plus memory model
    modport master (
        output req0, addr0, req1, addr1, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, err, busy, mem_addr
    );

    // Arbiter
    modport slave (
        input  req0, addr0, req1, addr1, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, err, busy, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Brief    : Round-robin arbiter sharing one synchronous-read word memory
//            between instruction fetch (port 0) and data load (port 1).
//            Misaligned or out-of-range addresses are answered with an error
//            response without issuing a memory read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32,
    parameter int DEPTH      = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_read_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int IDXW = ADDRESSLEN - 2;
    // DEPTH equal to the full index space cannot be represented in IDXW bits;
    // in that case no index is ever out of range.
    localparam bit              c_FULL_RANGE = (longint'(DEPTH) >= (longint'(1) << IDXW));
    localparam logic [IDXW-1:0] c_DEPTH_IDX  = IDXW'(DEPTH);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_port;
    logic                  r_port_q;
    logic [ADDRESSLEN-1:0] r_mem_addr;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic [ADDRESSLEN-1:0] w_sel_addr;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_addr_err;
    logic                  w_rvalid0;
    logic                  w_rvalid1;
    logic [XLEN-1:0]       w_rdata;
    logic                  w_err;

    // Grant: only in IDLE and never during reset; on contention the port that
    // did not win last time is served.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE && !reset) begin
            if (bus.req0 && bus.req1) begin
                w_gnt0 = r_last_port;
                w_gnt1 = !r_last_port;
            end else begin
                w_gnt0 = bus.req0;
                w_gnt1 = bus.req1;
            end
        end
    end

    assign w_accept       = w_gnt0 | w_gnt1;
    assign w_sel_addr     = w_gnt1 ? bus.addr1 : bus.addr0;
    assign w_misaligned   = (w_sel_addr[1:0] != 2'b00);
    assign w_out_of_range = !c_FULL_RANGE && (w_sel_addr[ADDRESSLEN-1:2] >= c_DEPTH_IDX);
    assign w_addr_err     = w_misaligned | w_out_of_range;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and response outputs; reset squashes any in-flight response.
    always_comb begin
        w_next_state = r_state;
        w_rvalid0    = 1'b0;
        w_rvalid1    = 1'b0;
        w_rdata      = '0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_addr_err ? S_ERR : S_BUSY;
                end
            end
            S_BUSY: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_rvalid0    = !r_port_q;
                w_rvalid1    = r_port_q;
                w_rdata      = bus.mem_rdata;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                w_rvalid0    = !r_port_q;
                w_rvalid1    = r_port_q;
                w_err        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (reset) begin
            w_rvalid0 = 1'b0;
            w_rvalid1 = 1'b0;
            w_rdata   = '0;
            w_err     = 1'b0;
        end
    end

    // Winner bookkeeping and memory address; the address only moves for a
    // legal access so an error leaves the memory untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_port <= 1'b1;
            r_port_q    <= 1'b0;
            r_mem_addr  <= '0;
        end else if (w_accept) begin
            r_last_port <= w_gnt1;
            r_port_q    <= w_gnt1;
            if (!w_addr_err) begin
                r_mem_addr <= w_sel_addr;
            end
        end
    end

    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.rvalid0  = w_rvalid0;
    assign bus.rvalid1  = w_rvalid1;
    assign bus.rdata    = w_rdata;
    assign bus.err      = w_err;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_read_arbiter
// Brief    : Self-checking bench for mem_read_arbiter: table of single-port
//            reads plus hand-written arbitration and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;

    localparam int XLEN       = 32;
    localparam int ADDRESSLEN = 32;
    localparam int DEPTH      = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [ADDRESSLEN-1:0] exp_mem_addr;
    logic [XLEN-1:0]       mem [DEPTH];

    mem_read_arbiter_if #(.XLEN(XLEN), .ADDRESSLEN(ADDRESSLEN)) bus ();

    mem_read_arbiter #(
        .XLEN       (XLEN),
        .ADDRESSLEN (ADDRESSLEN),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request from IDLE; leaves the bench in the next IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] want_rv;
        want_rv = v.port ? 2'b10 : 2'b01;
        if (v.port) begin bus.req1 = 1'b1; bus.addr1 = v.addr; end
        else        begin bus.req0 = 1'b1; bus.addr0 = v.addr; end
        #1;
        chk($sformatf("v%0d gnt", idx), {bus.gnt1, bus.gnt0}, want_rv);
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        if (v.exp_err) begin
            chk($sformatf("v%0d err rvalid", idx), {bus.rvalid1, bus.rvalid0}, want_rv);
            chk($sformatf("v%0d err flag", idx), bus.err, 1'b1);
            chk($sformatf("v%0d err rdata", idx), bus.rdata, 32'h0);
            chk($sformatf("v%0d err mem_addr", idx), bus.mem_addr, exp_mem_addr);
        end else begin
            chk($sformatf("v%0d busy", idx), bus.busy, 1'b1);
            chk($sformatf("v%0d early rvalid", idx), {bus.rvalid1, bus.rvalid0}, 2'b00);
            chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
            exp_mem_addr = v.addr;
            tick();
            chk($sformatf("v%0d rvalid", idx), {bus.rvalid1, bus.rvalid0}, want_rv);
            chk($sformatf("v%0d err flag", idx), bus.err, 1'b0);
            chk($sformatf("v%0d rdata", idx), bus.rdata, v.exp_data);
        end
        tick();
        chk($sformatf("v%0d idle busy", idx), bus.busy, 1'b0);
        chk($sformatf("v%0d idle rvalid", idx), {bus.rvalid1, bus.rvalid0}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[2] = 32'hDEAD_BEEF;

        vecs[0] = '{1'b0, 32'h0000_0008, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0006, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0040, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_003C, 1'b0, 32'hC0DE_000F};
        vecs[4] = '{1'b1, 32'h0000_0000, 1'b0, 32'hC0DE_0000};
        vecs[5] = '{1'b1, 32'h0000_0001, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0024, 1'b0, 32'hC0DE_0009};

        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        reset     = 1'b1;
        tick();
        tick();
        chk("rst busy", bus.busy, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk("post-rst rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        chk("post-rst rdata", bus.rdata, 32'h0);
        chk("post-rst err", bus.err, 1'b0);
        chk("post-rst gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        exp_mem_addr = '0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both ports held: strict alternation starting with port 0 after reset.
        reset     = 1'b1;
        bus.req0  = 1'b1;
        bus.addr0 = 32'h4;
        bus.req1  = 1'b1;
        bus.addr1 = 32'h8;
        #1;
        chk("rr gnt in reset", {bus.gnt1, bus.gnt0}, 2'b00);
        tick();
        chk("rr gnt in reset 2", {bus.gnt1, bus.gnt0}, 2'b00);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 18; c++) begin
            int k;
            k = c / 3;
            if (c % 3 == 0)
                chk($sformatf("rr gnt c%0d", c), {bus.gnt1, bus.gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
            else
                chk($sformatf("rr no gnt c%0d", c), {bus.gnt1, bus.gnt0}, 2'b00);
            if (c % 3 == 2) begin
                chk($sformatf("rr rvalid c%0d", c), {bus.rvalid1, bus.rvalid0}, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk($sformatf("rr rdata c%0d", c), bus.rdata, (k % 2 == 0) ? 32'hC0DE_0001 : 32'hDEAD_BEEF);
            end
            if (c == 17) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick();
        end
        chk("rr idle after", bus.busy, 1'b0);

        // Reset while BUSY drops the response; port 1 served right after release.
        bus.req0  = 1'b1;
        bus.addr0 = 32'h8;
        #1;
        chk("rb gnt0", bus.gnt0, 1'b1);
        tick();
        bus.req0  = 1'b0;
        reset     = 1'b1;
        bus.req1  = 1'b1;
        bus.addr1 = 32'h14;
        #1;
        chk("rb gnt1 in busy+reset", bus.gnt1, 1'b0);
        tick();
        chk("rb dropped rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        chk("rb gnt1 in idle+reset", bus.gnt1, 1'b0);
        chk("rb mem_addr reset", bus.mem_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk("rb gnt1 after release", {bus.gnt1, bus.gnt0}, 2'b10);
        tick();
        bus.req1 = 1'b0;
        #1;
        chk("rb rvalid early", {bus.rvalid1, bus.rvalid0}, 2'b00);
        chk("rb mem_addr", bus.mem_addr, 32'h14);
        tick();
        chk("rb rvalid1", {bus.rvalid1, bus.rvalid0}, 2'b10);
        chk("rb rdata", bus.rdata, 32'hC0DE_0005);
        tick();

        // Port 1 raises its request mid-transaction and waits for IDLE.
        bus.req0  = 1'b1;
        bus.addr0 = 32'hC;
        #1;
        chk("mid gnt0", {bus.gnt1, bus.gnt0}, 2'b01);
        tick();
        bus.req0  = 1'b0;
        bus.req1  = 1'b1;
        bus.addr1 = 32'h30;
        #1;
        chk("mid gnt1 in busy", bus.gnt1, 1'b0);
        tick();
        chk("mid gnt1 in resp", bus.gnt1, 1'b0);
        chk("mid port0 rvalid", {bus.rvalid1, bus.rvalid0}, 2'b01);
        chk("mid port0 rdata", bus.rdata, 32'hC0DE_0003);
        tick();
        chk("mid gnt1 in idle", {bus.gnt1, bus.gnt0}, 2'b10);
        tick();
        bus.req1 = 1'b0;
        #1;
        chk("mid port1 early", {bus.rvalid1, bus.rvalid0}, 2'b00);
        tick();
        chk("mid port1 rvalid", {bus.rvalid1, bus.rvalid0}, 2'b10);
        chk("mid port1 rdata", bus.rdata, 32'hC0DE_000C);
        chk("mid port1 err", bus.err, 1'b0);
        tick();
        chk("mid idle", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
